// File: rtl/kalman_pkg.sv
// Shared constants and FSM encoding for the kalman_core gain/update stages.
// Q2.14 operands, Q5.28 accumulation, Q5.14 intermediate after rounding.
package kalman_pkg;

  localparam int W     = 16;
  localparam int FRAC  = 14;
  localparam int ACC_W = 33;
  localparam int RW    = ACC_W - FRAC;

  localparam logic signed [ACC_W-1:0] ROUND_CONST = 33'sd8192;
  localparam logic [W-1:0] Q_MAX = 16'h7FFF;
  localparam logic [W-1:0] Q_MIN = 16'h8000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_MAC  = 2'd2,
    ST_DONE = 2'd3
  } kg_state_e;

endpackage

// File: rtl/q_round_sat.sv
// Rounds a Q5.28 sum to Q2.14 (half toward +inf) and flags out-of-range results.
// KGAIN_SAT_EN defined: clamp out-of-range values; undefined: keep the low 16 bits.
module q_round_sat
  import kalman_pkg::*;
(
  input  logic signed [ACC_W-1:0] sum_i,
  output logic        [W-1:0]     res_o,
  output logic                    ovf_o
);

  logic signed [ACC_W-1:0] biased;
  logic signed [RW-1:0]    q;

  always_comb begin
    biased = sum_i + ROUND_CONST;
    q      = RW'(biased >>> FRAC);
    // In range only when the bits above the Q2.14 sign all copy that sign.
    ovf_o  = (q[RW-1:W-1] != '0) && (q[RW-1:W-1] != '1);
`ifdef KGAIN_SAT_EN
    if (ovf_o) res_o = q[RW-1] ? Q_MIN : Q_MAX;
    else       res_o = q[W-1:0];
`else
    res_o = q[W-1:0];
`endif
  end

endmodule

// File: rtl/kalman_gain.sv
// 2x2 Kalman gain K = PHt x S_inv on one shared 16x16 multiplier and accumulator.
// Optional clamping of out-of-range gain elements via KGAIN_SAT_EN.
module kalman_gain
  import kalman_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         inv_error,
  input  logic [W-1:0] p_a,
  input  logic [W-1:0] p_b,
  input  logic [W-1:0] p_c,
  input  logic [W-1:0] p_d,
  input  logic [W-1:0] s_a,
  input  logic [W-1:0] s_b,
  input  logic [W-1:0] s_c,
  input  logic [W-1:0] s_d,
  output logic [W-1:0] k_a,
  output logic [W-1:0] k_b,
  output logic [W-1:0] k_c,
  output logic [W-1:0] k_d,
  output logic         busy,
  output logic         ready,
  output logic         error,
  output logic         overflow,
  output logic [1:0]   dbg_state
);

  // Handshake: start is a one-cycle request accepted only in IDLE; ready is a
  // one-cycle pulse in DONE and k_*/error/overflow stay valid until the next LOAD.

  kg_state_e state_q, state_d;
  logic signed [W-1:0] p_q [4];
  logic signed [W-1:0] p_d_arr [4];
  logic signed [W-1:0] s_q [4];
  logic signed [W-1:0] s_d_arr [4];
  logic [W-1:0] k_q [4];
  logic [W-1:0] k_d_arr [4];
  logic inv_q, inv_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [2:0] cnt_q, cnt_d;
  logic ovf_q, ovf_d;
  logic err_q, err_d;

  logic signed [2*W-1:0]   prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] sum;
  logic [W-1:0]            rnd_res;
  logic                    rnd_ovf;

  // cnt = {r, c, t}: P[r][t] lives at index {r,t}, S[t][c] at index {t,c}.
  always_comb begin
    prod     = p_q[{cnt_q[2], cnt_q[0]}] * s_q[{cnt_q[0], cnt_q[1]}];
    prod_ext = {prod[2*W-1], prod};
    sum      = acc_q + prod_ext;
  end

  q_round_sat u_round (
    .sum_i (sum),
    .res_o (rnd_res),
    .ovf_o (rnd_ovf)
  );

  always_comb begin
    state_d = state_q;
    p_d_arr = p_q;
    s_d_arr = s_q;
    k_d_arr = k_q;
    inv_d   = inv_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
          p_d_arr = '{p_a, p_b, p_c, p_d};
          s_d_arr = '{s_a, s_b, s_c, s_d};
          inv_d   = inv_error;
        end
      end
      ST_LOAD: begin
        acc_d = '0;
        cnt_d = '0;
        ovf_d = 1'b0;
        err_d = 1'b0;
        if (inv_q) begin
          state_d = ST_DONE;
          k_d_arr = '{default: '0};
          err_d   = 1'b1;
        end else begin
          state_d = ST_MAC;
        end
      end
      ST_MAC: begin
        cnt_d = cnt_q + 3'd1;
        if (!cnt_q[0]) begin
          acc_d = prod_ext;
        end else begin
          k_d_arr[cnt_q[2:1]] = rnd_res;
          ovf_d = ovf_q | rnd_ovf;
        end
        if (cnt_q == 3'd7) begin
          state_d = ST_DONE;
          err_d   = inv_q;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      p_q     <= '{default: '0};
      s_q     <= '{default: '0};
      k_q     <= '{default: '0};
      inv_q   <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d_arr;
      s_q     <= s_d_arr;
      k_q     <= k_d_arr;
      inv_q   <= inv_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  assign k_a       = k_q[0];
  assign k_b       = k_q[1];
  assign k_c       = k_q[2];
  assign k_d       = k_q[3];
  assign busy      = (state_q == ST_LOAD) || (state_q == ST_MAC);
  assign ready     = (state_q == ST_DONE);
  assign error     = err_q;
  assign overflow  = ovf_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_kalman_gain.sv
// Table-driven bench for kalman_gain with an expected-result queue and corner sequences.
module tb_kalman_gain;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        inv_error;
  logic [15:0] p_a, p_b, p_c, p_d;
  logic [15:0] s_a, s_b, s_c, s_d;
  logic [15:0] k_a, k_b, k_c, k_d;
  logic        busy, ready, error, overflow;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  kalman_gain dut (
    .clk(clk), .reset(reset), .start(start), .inv_error(inv_error),
    .p_a(p_a), .p_b(p_b), .p_c(p_c), .p_d(p_d),
    .s_a(s_a), .s_b(s_b), .s_c(s_c), .s_d(s_d),
    .k_a(k_a), .k_b(k_b), .k_c(k_c), .k_d(k_d),
    .busy(busy), .ready(ready), .error(error), .overflow(overflow),
    .dbg_state(dbg_state)
  );

  typedef struct {
    logic [15:0] p [4];
    logic [15:0] s [4];
    logic        inv;
    logic [15:0] k [4];
    logic        ovf;
    logic        err;
    int          lat;
  } vec_t;

  localparam int NVEC = 12;
  vec_t tbl [NVEC];
  logic [65:0] exp_q [$];
  int checks = 0;
  int failures = 0;
  int ready_cnt = 0;

  always @(posedge clk) if (ready) ready_cnt++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
    end
  endtask

  // Reference: exact integer sum, round half up, then wrap or clamp.
  function automatic void model(input logic [15:0] p [4], input logic [15:0] s [4],
                                output logic [15:0] k [4], output logic ovf);
    longint sum, q;
    ovf = 1'b0;
    for (int e = 0; e < 4; e++) begin
      int r, c;
      r = e / 2;
      c = e % 2;
      sum = longint'($signed(p[r*2])) * longint'($signed(s[c]))
          + longint'($signed(p[r*2+1])) * longint'($signed(s[2+c]));
      q = (sum + 64'sd8192) >>> 14;
      if (q > 32767 || q < -32768) ovf = 1'b1;
`ifdef KGAIN_SAT_EN
      if (q > 32767)       k[e] = 16'h7FFF;
      else if (q < -32768) k[e] = 16'h8000;
      else                 k[e] = q[15:0];
`else
      k[e] = q[15:0];
`endif
    end
  endfunction

  task automatic set_ops(input logic [15:0] p [4], input logic [15:0] s [4], input logic inv);
    p_a = p[0]; p_b = p[1]; p_c = p[2]; p_d = p[3];
    s_a = s[0]; s_b = s[1]; s_c = s[2]; s_d = s[3];
    inv_error = inv;
  endtask

  task automatic compare_out(input string tag);
    logic [65:0] e;
    e = exp_q.pop_front();
    chk({tag, "_k_a"}, k_a, e[65:50]);
    chk({tag, "_k_b"}, k_b, e[49:34]);
    chk({tag, "_k_c"}, k_c, e[33:18]);
    chk({tag, "_k_d"}, k_d, e[17:2]);
    chk({tag, "_overflow"}, overflow, e[1]);
    chk({tag, "_error"}, error, e[0]);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int lat;
    bit seen;
    seen = 0;
    lat = 0;
    set_ops(v.p, v.s, v.inv);
    start = 1'b1;
    exp_q.push_back({v.k[0], v.k[1], v.k[2], v.k[3], v.ovf, v.err});
    for (int cyc = 1; cyc <= 20 && !seen; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        start = 1'b0;
        chk({tag, "_busy_load"}, busy, 1'b1);
      end
      if (ready) begin
        seen = 1;
        lat = cyc;
      end
    end
    if (!seen) begin
      chk({tag, "_ready_timeout"}, 0, 1);
      void'(exp_q.pop_front());
    end else begin
      chk({tag, "_latency"}, lat, v.lat);
      chk({tag, "_busy_done"}, busy, 1'b0);
      compare_out(tag);
    end
    inv_error = 1'b0;
  endtask

  initial begin
    logic [15:0] kk [4];
    logic ov;
    int rc0;
    vec_t v;
    reset = 1'b0;
    start = 1'b0;
    inv_error = 1'b0;
    {p_a, p_b, p_c, p_d, s_a, s_b, s_c, s_d} = '0;
    repeat (3) @(negedge clk);
    chk("reset_k", {k_a, k_b, k_c, k_d}, 64'h0);
    chk("reset_flags", {busy, ready, error, overflow}, 4'b0000);
    chk("reset_state", dbg_state, 2'd0);
    reset = 1'b1;
    @(negedge clk);

    tbl[0].p = '{16'h4000, 16'h0000, 16'h0000, 16'h4000};
    tbl[0].s = '{16'h2000, 16'h1000, 16'h0800, 16'h4000};
    tbl[0].inv = 0; tbl[0].k = '{16'h2000, 16'h1000, 16'h0800, 16'h4000};
    tbl[0].ovf = 0; tbl[0].err = 0; tbl[0].lat = 10;

    tbl[1].p = '{default: 16'h4000};
    tbl[1].s = '{default: 16'h4000};
    tbl[1].inv = 0;
`ifdef KGAIN_SAT_EN
    tbl[1].k = '{default: 16'h7FFF};
`else
    tbl[1].k = '{default: 16'h8000};
`endif
    tbl[1].ovf = 1; tbl[1].err = 0; tbl[1].lat = 10;

    tbl[2].p = '{default: 16'h4000};
    tbl[2].s = '{default: 16'h4000};
    tbl[2].inv = 1; tbl[2].k = '{default: 16'h0000};
    tbl[2].ovf = 0; tbl[2].err = 1; tbl[2].lat = 2;

    tbl[3].p = '{16'h0001, 16'h0000, 16'h0000, 16'h0000};
    tbl[3].s = '{16'h2000, 16'h0000, 16'h0000, 16'h0000};
    tbl[3].inv = 0; tbl[3].k = '{16'h0001, 16'h0000, 16'h0000, 16'h0000};
    tbl[3].ovf = 0; tbl[3].err = 0; tbl[3].lat = 10;

    tbl[4].p = '{16'hFFFF, 16'h0000, 16'h0000, 16'h0000};
    tbl[4].s = '{16'h2000, 16'h0000, 16'h0000, 16'h0000};
    tbl[4].inv = 0; tbl[4].k = '{default: 16'h0000};
    tbl[4].ovf = 0; tbl[4].err = 0; tbl[4].lat = 10;

    for (int i = 5; i < NVEC; i++) begin
      for (int j = 0; j < 4; j++) begin
        if (i % 2 == 0) begin
          rc0 = int'($urandom_range(0, 16'h4000)) - 16'h2000;
          tbl[i].p[j] = rc0[15:0];
          rc0 = int'($urandom_range(0, 16'h4000)) - 16'h2000;
          tbl[i].s[j] = rc0[15:0];
        end else begin
          tbl[i].p[j] = 16'($urandom_range(0, 16'hFFFF));
          tbl[i].s[j] = 16'($urandom_range(0, 16'hFFFF));
        end
      end
      model(tbl[i].p, tbl[i].s, kk, ov);
      tbl[i].k = kk;
      tbl[i].ovf = ov;
      tbl[i].inv = 0; tbl[i].err = 0; tbl[i].lat = 10;
    end

    rc0 = ready_cnt;
    for (int i = 0; i < NVEC; i++) begin
      run_vec(tbl[i], $sformatf("vec%0d", i));
      @(negedge clk);
    end
    chk("ready_pulses_table", ready_cnt - rc0, NVEC);

    // Reset during MAC: outputs clear at once and no ready follows.
    run_vec(tbl[0], "pre_reset");
    set_ops(tbl[1].p, tbl[1].s, 1'b0);
    start = 1'b1;
    for (int cyc = 1; cyc <= 5; cyc++) begin
      @(negedge clk);
      if (cyc == 1) start = 1'b0;
    end
    rc0 = ready_cnt;
    reset = 1'b0;
    #1;
    chk("midreset_k", {k_a, k_b, k_c, k_d}, 64'h0);
    chk("midreset_flags", {busy, ready, error, overflow}, 4'b0000);
    repeat (4) @(negedge clk);
    chk("midreset_no_ready", ready_cnt - rc0, 0);
    reset = 1'b1;
    @(negedge clk);
    run_vec(tbl[3], "post_reset");
    @(negedge clk);

    // start re-asserted mid-MAC with new operands: ignored.
    v = tbl[7];
    rc0 = ready_cnt;
    set_ops(v.p, v.s, 1'b0);
    start = 1'b1;
    exp_q.push_back({v.k[0], v.k[1], v.k[2], v.k[3], v.ovf, v.err});
    begin
      int lat;
      lat = 0;
      for (int cyc = 1; cyc <= 20 && lat == 0; cyc++) begin
        @(negedge clk);
        if (cyc == 1) start = 1'b0;
        if (cyc == 4) begin
          set_ops(tbl[1].p, tbl[1].s, 1'b1);
          start = 1'b1;
        end
        if (cyc == 5) start = 1'b0;
        if (ready) lat = cyc;
      end
      inv_error = 1'b0;
      if (lat == 0) begin
        chk("restart_ready_timeout", 0, 1);
        void'(exp_q.pop_front());
      end else begin
        chk("restart_latency", lat, 10);
        compare_out("restart");
      end
    end
    repeat (15) @(negedge clk);
    chk("restart_one_pulse", ready_cnt - rc0, 1);
    chk("restart_idle", dbg_state, 2'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
